mov_sprite_fetch: RTL and testbench
===================================

Name: mov_sprite_fetch

Overview:
Upstream address generator for the moving-sprite pattern memory. Holds a table of NUM_OBJ moving-sprite objects (position, pattern number, visible).
- During horizontal blank: scans the table and loads up to LINE_SLOTS objects that overlap the upcoming line.
- During active video: emits per pixel the 6-bit pattern select plus 4-bit x/y pixel offsets for the pattern memory.
- Emits a hit flag aligned with the memory's registered 2-bit output, for the downstream compositor.

Parameters:
NUM_OBJ, 8, number of object table entries (power of 2, max 16)
LINE_SLOTS, 4, max objects rendered per scanline
H_BITS, 10, width of horizontal pixel coordinate
V_BITS, 10, width of vertical pixel coordinate

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe into shadow object table
wr_idx  in  log2(NUM_OBJ)  object entry written
wr_x  in  H_BITS  object left edge, screen pixels
wr_y  in  V_BITS  object top edge, screen lines
wr_sel  in  6  pattern number (0..63)
wr_vis  in  1  object visible
wr_flip  in  2  {vflip,hflip}; used only with optional feature
frame_start  in  1  one-cycle pulse at start of vertical blank
line_start  in  1  one-cycle pulse at start of horizontal blank
line_y  in  V_BITS  line number that will be displayed after this blank
pix_x  in  H_BITS  current active pixel column
pix_valid  in  1  active video pixel
select  out  6  pattern number to sprite memory
x  out  4  column within 16x16 pattern
y  out  4  row within 16x16 pattern
hit  out  1  sprite pixel present; aligned with memory q (2 cycles after pix_x)
obj_idx  out  log2(NUM_OBJ)  winning object, aligned with hit
overflow  out  1  more than LINE_SLOTS objects on current line

Behaviour:
- Reset: shadow and active tables cleared (vis=0, fields 0); slots empty; FSM IDLE; select/x/y/hit/obj_idx/overflow = 0.
- Writes: wr_en updates the shadow entry at the clock edge. Active table = shadow copy taken at frame_start. A write coincident with frame_start lands in shadow only and is not in the copy (commits next frame).
- FSM states: IDLE, SCAN, READY.
  - IDLE/READY + line_start: clear slots, latch line_y, clear overflow, scan index = 0, go SCAN.
  - SCAN examines one entry per cycle, index 0..NUM_OBJ-1. Entry qualifies if vis=1 and 0 <= line_y - obj_y <= 15, computed in V_BITS+1 bits (no wrap-around).
  - Qualifying entry fills the next free slot in index order. If all slots are full, set overflow and drop the entry.
  - After index NUM_OBJ-1, go READY. Scan takes exactly NUM_OBJ cycles.
  - line_start during SCAN restarts the scan. frame_start does not disturb the FSM.
- Pixel stage 1 (registered, 1 cycle after pix_x):
  - For each slot, dx = pix_x - slot_x in H_BITS+1 bits; slot hits if 0 <= dx <= 15.
  - Lowest slot wins (equivalent to lowest object index).
  - Register select = slot_sel, x = dx[3:0], y = (line_y - slot_y)[3:0], hit_p.
  - No hit, pix_valid=0, or FSM not READY: hit_p = 0 and select/x/y hold previous values.
- Pixel stage 2: hit and obj_idx = stage-1 values delayed 1 cycle, aligning them with the memory's q.
- Offscreen partials: objects at x near 2^H_BITS or y near 2^V_BITS clip naturally (extended-width compare). Negative positions are not supported.
- Timing contract: horizontal blank must be >= NUM_OBJ+1 cycles. Pixels presented before READY produce hit=0.

Optional Feature:
MOV_SPRITE_FLIP_EN
- Defined: wr_flip is stored per entry. hflip gives x = 15 - dx[3:0]; vflip gives y = 15 - dy[3:0].
- Undefined: wr_flip is ignored, no flip storage is built, and x/y are unflipped.

Test Plan:
1. Reset, frame_start, line_start line_y=5, sweep pix_x 0..639 -> hit=0 everywhere, overflow=0.
2. Write obj0 x=100 y=0 sel=3 vis=1, frame_start, line_start line_y=7, pix_x=100..115 -> select=3, y=7, x=0..15, hit=1 two cycles after each pix_x; pix_x=99 and 116 -> hit=0.
3. obj2 and obj5 both at x=200, y=0 (sel 9 and 12), line_y=0, pix_x=205 -> select=9, obj_idx=2, x=5.
4. Six visible objects all y=10, line_y=12 -> objects 0..3 rendered, 4 and 5 never hit, overflow=1; next line_start with line_y=40 -> overflow=0.
5. Write obj0 x=300 coincident with frame_start -> current frame still uses old x; after the next frame_start, x=300 is used. Write mid-frame with no frame_start -> display unchanged.
6. line_start, then a second line_start 3 cycles later with a different line_y -> scan restarts and the slots reflect the second line_y. With MOV_SPRITE_FLIP_EN, hflip=1 at dx=2 -> x=13.

Source files
------------

// File: rtl/mov_sprite_fetch_if.sv
// Object-table write bus for mov_sprite_fetch.
// The master drives writes; the sprite fetch block is the slave.
interface mov_sprite_fetch_if #(
    parameter int IW     = 3,
    parameter int H_BITS = 10,
    parameter int V_BITS = 10
);
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [H_BITS-1:0] wr_x;
    logic [V_BITS-1:0] wr_y;
    logic [5:0]        wr_sel;
    logic              wr_vis;
    logic [1:0]        wr_flip;

    modport master (
        output wr_en, wr_idx, wr_x, wr_y,
        output wr_sel, wr_vis, wr_flip
    );
    modport slave (
        input wr_en, wr_idx, wr_x, wr_y,
        input wr_sel, wr_vis, wr_flip
    );
endinterface

// File: rtl/mov_sprite_fetch.sv
// Moving-sprite line loader and pattern-memory address generator.
// Define MOV_SPRITE_FLIP_EN to store and apply per-object {vflip,hflip}.
module mov_sprite_fetch #(
    parameter int NUM_OBJ    = 8,
    parameter int LINE_SLOTS = 4,
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 10,
    localparam int IW        = $clog2(NUM_OBJ)
) (
    input  logic              clock,
    input  logic              reset,
    mov_sprite_fetch_if.slave wr,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [V_BITS-1:0] line_y,
    input  logic [H_BITS-1:0] pix_x,
    input  logic              pix_valid,
    output logic [5:0]        select,
    output logic [3:0]        x,
    output logic [3:0]        y,
    output logic              hit,
    output logic [IW-1:0]     obj_idx,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

    typedef struct packed {
`ifdef MOV_SPRITE_FLIP_EN
        logic [1:0]        flip;
`endif
        logic              vis;
        logic [5:0]        sel;
        logic [V_BITS-1:0] y;
        logic [H_BITS-1:0] x;
    } obj_t;

    typedef struct packed {
`ifdef MOV_SPRITE_FLIP_EN
        logic [1:0]        flip;
`endif
        logic [IW-1:0]     idx;
        logic [5:0]        sel;
        logic [3:0]        dy;
        logic [H_BITS-1:0] x;
    } slot_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         scan_q, scan_d;
    logic [V_BITS-1:0]     ly_q, ly_d;
    obj_t                  sh_q [NUM_OBJ];
    obj_t                  sh_d [NUM_OBJ];
    obj_t                  act_q [NUM_OBJ];
    obj_t                  act_d [NUM_OBJ];
    slot_t                 slot_q [LINE_SLOTS];
    slot_t                 slot_d [LINE_SLOTS];
    logic [LINE_SLOTS-1:0] vld_q, vld_d;
    logic                  ovf_q, ovf_d;
    logic [5:0]            sel_q, sel_d;
    logic [3:0]            x_q, x_d, y_q, y_d;
    logic                  hit_p_q, hit_p_d;
    logic [IW-1:0]         idx_p_q, idx_p_d;
    logic                  hit_q, hit_d;
    logic [IW-1:0]         oidx_q, oidx_d;

    obj_t                  cur;
    logic [V_BITS:0]       dy;
    logic                  taken;
    logic [H_BITS:0]       dx;
    slot_t                 win;
    logic [3:0]            win_dx;
    logic                  found;

    // Active copy takes the pre-edge shadow, so a coincident write waits a frame.
    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        if (frame_start) act_d = sh_q;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (wr.wr_en && wr.wr_idx == IW'(i)) begin
                sh_d[i].x   = wr.wr_x;
                sh_d[i].y   = wr.wr_y;
                sh_d[i].sel = wr.wr_sel;
                sh_d[i].vis = wr.wr_vis;
`ifdef MOV_SPRITE_FLIP_EN
                sh_d[i].flip = wr.wr_flip;
`endif
            end
        end
    end

`ifndef MOV_SPRITE_FLIP_EN
    logic unused_flip;
    assign unused_flip = ^wr.wr_flip;
`endif

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        ly_d    = ly_q;
        slot_d  = slot_q;
        vld_d   = vld_q;
        ovf_d   = ovf_q;
        taken   = 1'b0;
        cur     = act_q[scan_q];
        dy      = {1'b0, ly_q} - {1'b0, cur.y};
        if (line_start) begin
            state_d = SCAN;
            scan_d  = '0;
            ly_d    = line_y;
            vld_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == SCAN) begin
            if (cur.vis && dy[V_BITS:4] == '0) begin
                for (int s = 0; s < LINE_SLOTS; s++) begin
                    if (!vld_q[s] && !taken) begin
                        taken         = 1'b1;
                        vld_d[s]      = 1'b1;
                        slot_d[s].x   = cur.x;
                        slot_d[s].sel = cur.sel;
                        slot_d[s].dy  = dy[3:0];
                        slot_d[s].idx = scan_q;
`ifdef MOV_SPRITE_FLIP_EN
                        slot_d[s].flip = cur.flip;
`endif
                    end
                end
                if (!taken) ovf_d = 1'b1;
            end
            if (scan_q == IW'(NUM_OBJ - 1)) state_d = READY;
            scan_d = scan_q + 1'b1;
        end
    end

    // Lowest occupied slot wins, which is also the lowest object index.
    always_comb begin
        dx      = '0;
        win     = '0;
        win_dx  = '0;
        found   = 1'b0;
        for (int s = 0; s < LINE_SLOTS; s++) begin
            dx = {1'b0, pix_x} - {1'b0, slot_q[s].x};
            if (!found && vld_q[s] && dx[H_BITS:4] == '0) begin
                found  = 1'b1;
                win    = slot_q[s];
                win_dx = dx[3:0];
            end
        end
        hit_p_d = 1'b0;
        sel_d   = sel_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_p_d = idx_p_q;
        if (found && pix_valid && state_q == READY) begin
            hit_p_d = 1'b1;
            sel_d   = win.sel;
            idx_p_d = win.idx;
`ifdef MOV_SPRITE_FLIP_EN
            x_d = win.flip[0] ? ~win_dx : win_dx;
            y_d = win.flip[1] ? ~win.dy : win.dy;
`else
            x_d = win_dx;
            y_d = win.dy;
`endif
        end
        hit_d  = hit_p_q;
        oidx_d = idx_p_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            scan_q  <= '0;
            ly_q    <= '0;
            sh_q    <= '{default: '0};
            act_q   <= '{default: '0};
            slot_q  <= '{default: '0};
            vld_q   <= '0;
            ovf_q   <= 1'b0;
            sel_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hit_p_q <= 1'b0;
            idx_p_q <= '0;
            hit_q   <= 1'b0;
            oidx_q  <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            ly_q    <= ly_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
            slot_q  <= slot_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            sel_q   <= sel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hit_p_q <= hit_p_d;
            idx_p_q <= idx_p_d;
            hit_q   <= hit_d;
            oidx_q  <= oidx_d;
        end
    end

    assign select   = sel_q;
    assign x        = x_q;
    assign y        = y_q;
    assign hit      = hit_q;
    assign obj_idx  = oidx_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mov_sprite_fetch.sv
// Random and directed checks of mov_sprite_fetch against a list-based model.
// Honours MOV_SPRITE_FLIP_EN the same way the design does.
module tb_mov_sprite_fetch;
    localparam int NUM_OBJ    = 8;
    localparam int LINE_SLOTS = 4;
    localparam int H_BITS     = 10;
    localparam int V_BITS     = 10;
    localparam int IW         = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              frame_start, line_start, pix_valid;
    logic [V_BITS-1:0] line_y;
    logic [H_BITS-1:0] pix_x;
    logic [5:0]        select;
    logic [3:0]        x, y;
    logic              hit;
    logic [IW-1:0]     obj_idx;
    logic              overflow;

    always #5 clock = ~clock;

    mov_sprite_fetch_if #(.IW(IW), .H_BITS(H_BITS), .V_BITS(V_BITS)) wr();

    mov_sprite_fetch #(
        .NUM_OBJ(NUM_OBJ), .LINE_SLOTS(LINE_SLOTS),
        .H_BITS(H_BITS), .V_BITS(V_BITS)
    ) dut (
        .clock(clock), .reset(reset), .wr(wr.slave),
        .frame_start(frame_start), .line_start(line_start),
        .line_y(line_y), .pix_x(pix_x), .pix_valid(pix_valid),
        .select(select), .x(x), .y(y), .hit(hit),
        .obj_idx(obj_idx), .overflow(overflow)
    );

    typedef struct {
        int x; int y; int sel; int vis; int flip; int idx;
    } mobj_t;

    int n_cmp = 0, n_bad = 0;
    mobj_t sh [NUM_OBJ];
    mobj_t ac [NUM_OBJ];
    mobj_t sl [$];
    int m_ly, m_ovf, cnt, started, armed = 0, ovf_chk;
    int s1_hit, s1_sel, s1_x, s1_y, s1_idx, e_hit, e_idx;
    int p_sel, p_x, p_y, p_hit, p_idx;
    int hitcnt [NUM_OBJ];
    int total;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model one clock edge from the inputs the DUT samples at that edge.
    task automatic model_edge();
        int rdy, found, d, wdx;
        mobj_t o;
        if (reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh[i] = '{default: 0};
                ac[i] = '{default: 0};
            end
            sl.delete();
            started = 0; cnt = 0; m_ovf = 0; m_ly = 0;
            s1_hit = 0; s1_sel = 0; s1_x = 0; s1_y = 0; s1_idx = 0;
            e_hit = 0; e_idx = 0; armed = 1; ovf_chk = 1;
            return;
        end
        rdy = (started != 0 && cnt == 0);
        e_hit = s1_hit;
        e_idx = s1_idx;
        found = 0; wdx = 0; o = '{default: 0};
        if (rdy && pix_valid) begin
            foreach (sl[k]) begin
                d = int'(pix_x) - sl[k].x;
                if (!found && d >= 0 && d <= 15) begin
                    found = 1; o = sl[k]; wdx = d;
                end
            end
        end
        s1_hit = found;
        if (found) begin
            s1_sel = o.sel;
            s1_idx = o.idx;
            s1_x   = wdx;
            s1_y   = m_ly - o.y;
`ifdef MOV_SPRITE_FLIP_EN
            if (o.flip & 1) s1_x = 15 - s1_x;
            if (o.flip & 2) s1_y = 15 - s1_y;
`endif
        end
        if (line_start) begin
            sl.delete();
            m_ovf = 0;
            m_ly  = int'(line_y);
            for (int i = 0; i < NUM_OBJ; i++) begin
                d = m_ly - ac[i].y;
                if (ac[i].vis != 0 && d >= 0 && d <= 15) begin
                    if (sl.size() < LINE_SLOTS) begin
                        o = ac[i];
                        o.idx = i;
                        sl.push_back(o);
                    end else m_ovf = 1;
                end
            end
            cnt = NUM_OBJ;
            started = 1;
        end else if (cnt > 0) cnt--;
        if (frame_start)
            for (int i = 0; i < NUM_OBJ; i++) ac[i] = sh[i];
        if (wr.wr_en) begin
            sh[int'(wr.wr_idx)] = '{x: int'(wr.wr_x), y: int'(wr.wr_y),
                                   sel: int'(wr.wr_sel),
                                   vis: int'(wr.wr_vis),
                                   flip: int'(wr.wr_flip), idx: 0};
        end
        ovf_chk = (started == 0 || cnt == 0);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (armed != 0) begin
                check("hit", int'(hit), e_hit);
                if (e_hit != 0) check("obj_idx", int'(obj_idx), e_idx);
                check("select", int'(select), s1_sel);
                check("x", int'(x), s1_x);
                check("y", int'(y), s1_y);
                if (ovf_chk != 0) check("overflow", int'(overflow), m_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic wr_obj(int idx, int xx, int yy, int sel,
                          int vis, int flip, int fs);
        wr.wr_en   = 1'b1;
        wr.wr_idx  = IW'(idx);
        wr.wr_x    = H_BITS'(xx);
        wr.wr_y    = V_BITS'(yy);
        wr.wr_sel  = 6'(sel);
        wr.wr_vis  = (vis != 0);
        wr.wr_flip = 2'(flip);
        frame_start = (fs != 0);
        tick();
        wr.wr_en = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic new_line(int ly);
        line_y = V_BITS'(ly);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (NUM_OBJ + 2) tick();
    endtask

    task automatic probe(int px);
        pix_x = H_BITS'(px);
        pix_valid = 1'b1;
        tick();
        p_sel = int'(select); p_x = int'(x); p_y = int'(y);
        pix_valid = 1'b0;
        tick();
        p_hit = int'(hit); p_idx = int'(obj_idx);
    endtask

    task automatic sweep(int lo, int hi);
        total = 0;
        for (int i = 0; i < NUM_OBJ; i++) hitcnt[i] = 0;
        for (int p = lo; p <= hi + 2; p++) begin
            pix_valid = (p <= hi);
            pix_x = H_BITS'(p);
            tick();
            if (hit) begin
                total++;
                hitcnt[int'(obj_idx)]++;
            end
        end
        pix_valid = 1'b0;
    endtask

    function automatic int rx();
        return ($urandom_range(0, 5) == 0) ?
               int'($urandom_range(1008, 1023)) : int'($urandom_range(0, 150));
    endfunction

    function automatic int ry();
        return ($urandom_range(0, 5) == 0) ?
               int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 45));
    endfunction

    initial begin
        int w, base, ly, prev;
        reset = 1'b1;
        frame_start = 1'b0; line_start = 1'b0; pix_valid = 1'b0;
        line_y = '0; pix_x = '0;
        wr.wr_en = 1'b0; wr.wr_idx = '0; wr.wr_x = '0; wr.wr_y = '0;
        wr.wr_sel = '0; wr.wr_vis = 1'b0; wr.wr_flip = '0;
        repeat (3) tick();
        check("rst_hit", int'(hit), 0);
        check("rst_select", int'(select), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_obj_idx", int'(obj_idx), 0);
        reset = 1'b0;
        tick();

        pulse_frame();
        new_line(5);
        sweep(0, 639);
        check("t1_hits", total, 0);
        check("t1_overflow", int'(overflow), 0);

        wr_obj(0, 100, 0, 3, 1, 0, 0);
        pulse_frame();
        new_line(7);
        prev = 0;
        for (int p = 99; p <= 118; p++) begin
            pix_valid = (p <= 116);
            pix_x = H_BITS'(p);
            tick();
            if (p >= 100 && p <= 115) begin
                check("t2_select", int'(select), 3);
                check("t2_x", int'(x), p - 100);
                check("t2_y", int'(y), 7);
            end
            check("t2_hit", int'(hit), prev);
            prev = (p >= 100 && p <= 115) ? 1 : 0;
        end
        pix_valid = 1'b0;

        wr_obj(0, 100, 0, 3, 0, 0, 0);
        wr_obj(2, 200, 0, 9, 1, 0, 0);
        wr_obj(5, 200, 0, 12, 1, 0, 0);
        pulse_frame();
        new_line(0);
        probe(205);
        check("t3_select", p_sel, 9);
        check("t3_x", p_x, 5);
        check("t3_hit", p_hit, 1);
        check("t3_obj_idx", p_idx, 2);

        for (int i = 0; i < 6; i++) wr_obj(i, 50 + 20 * i, 10, i + 1, 1, 0, 0);
        pulse_frame();
        new_line(12);
        check("t4_overflow", int'(overflow), 1);
        sweep(40, 170);
        check("t4_obj0", hitcnt[0], 16);
        check("t4_obj3", hitcnt[3], 16);
        check("t4_obj4", hitcnt[4], 0);
        check("t4_obj5", hitcnt[5], 0);
        new_line(40);
        check("t4_overflow_clr", int'(overflow), 0);

        wr_obj(0, 300, 10, 1, 1, 0, 1);
        new_line(12);
        probe(55);
        check("t5_old_hit", p_hit, 1);
        check("t5_old_idx", p_idx, 0);
        probe(305);
        check("t5_new_not_yet", p_hit, 0);
        pulse_frame();
        new_line(12);
        probe(305);
        check("t5_new_hit", p_hit, 1);
        check("t5_new_x", p_x, 5);
        wr_obj(0, 500, 10, 1, 1, 0, 0);
        new_line(12);
        probe(305);
        check("t5_midframe_hold", p_hit, 1);
        probe(505);
        check("t5_midframe_new", p_hit, 0);

        wr_obj(7, 600, 95, 33, 1, 1, 0);
        pulse_frame();
        line_y = V_BITS'(12);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        tick();
        new_line(100);
        probe(75);
        check("t6_old_line", p_hit, 0);
        probe(602);
        check("t6_hit", p_hit, 1);
        check("t6_idx", p_idx, 7);
        check("t6_select", p_sel, 33);
        check("t6_y", p_y, 5);
`ifdef MOV_SPRITE_FLIP_EN
        check("t6_hflip_x", p_x, 13);
`else
        check("t6_x", p_x, 2);
`endif

        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < NUM_OBJ; i++)
                wr_obj(i, rx(), ry(), $urandom_range(0, 63),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 3), 0);
            wr_obj($urandom_range(0, NUM_OBJ - 1), rx(), ry(),
                   $urandom_range(0, 63), 1, $urandom_range(0, 3), 1);
            for (int l = 0; l < 4; l++) begin
                ly = ($urandom_range(0, 7) == 0) ?
                     int'($urandom_range(1005, 1023)) :
                     int'($urandom_range(0, 45));
                line_y = V_BITS'(ly);
                line_start = 1'b1;
                tick();
                line_start = 1'b0;
                w = $urandom_range(0, NUM_OBJ + 3);
                repeat (w) begin
                    pix_valid = $urandom_range(0, 1) != 0;
                    pix_x = H_BITS'($urandom_range(0, 1023));
                    wr.wr_en = $urandom_range(0, 3) == 0;
                    wr.wr_idx = IW'($urandom_range(0, NUM_OBJ - 1));
                    wr.wr_x = H_BITS'(rx());
                    wr.wr_y = V_BITS'(ry());
                    wr.wr_sel = 6'($urandom_range(0, 63));
                    wr.wr_vis = $urandom_range(0, 1) != 0;
                    wr.wr_flip = 2'($urandom_range(0, 3));
                    tick();
                end
                wr.wr_en = 1'b0;
                base = ($urandom_range(0, 3) == 0) ?
                       990 : int'($urandom_range(0, 100));
                for (int p = 0; p < 100; p++) begin
                    pix_x = H_BITS'((base + p) % 1024);
                    pix_valid = $urandom_range(0, 9) != 0;
                    tick();
                end
                pix_valid = 1'b0;
                tick();
            end
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
